// File: rtl/i2c_target_regfile.sv
// I2C target with a register-pointer protocol in front of an external byte register file.
// SCL/SDA are oversampled on clk; START/STOP override every state.
module i2c_target_regfile #(
  parameter logic [6:0]  DEV_ADDR    = 7'h42,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned REG_AW      = $clog2(NUM_REGS),
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          LSB_FIRST   = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy,
  output logic              start_det
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WDATA,
    S_WDATA_ACK, S_RDATA, S_RACK, S_NACK, S_IGNORE
  } state_e;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;

  state_e            state_q;
  logic [6:0]        shift_q;
  logic [7:0]        txbyte_q;
  logic [3:0]        bitcnt_q;
  logic              ack_ph_q, rw_q;
  logic [REG_AW-1:0] ptr_q, ptr_d, wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              sda_oe_q, wr_en_q, busy_q, start_det_q;

  logic [7:0] rx_byte, rx_rev, data_byte;
  logic [6:0] addr_rx;
  logic       ptr_ok, first_bit, cur_bit;

  // Synchronise the asynchronous bus lines and keep one previous sample for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign start_cond = scl_s & sda_prev_q & ~sda_s;
  assign stop_cond  = scl_s & ~sda_prev_q & sda_s;

  // Bits are always collected in arrival order (first bit at [7]); bit order is resolved on decode,
  // so the R/W bit stays the 8th arrival regardless of LSB_FIRST.
  assign rx_byte   = {shift_q, sda_s};
  assign rx_rev    = rev8(rx_byte);
  assign data_byte = LSB_FIRST ? rx_rev : rx_byte;
  assign addr_rx   = LSB_FIRST ? rx_rev[6:0] : rx_byte[7:1];
  assign ptr_ok    = ({24'd0, data_byte} < NUM_REGS);
  assign ptr_d     = (32'(ptr_q) == NUM_REGS - 32'd1) ? '0 : ptr_q + REG_AW'(1);
  assign first_bit = LSB_FIRST ? rd_data[0] : rd_data[7];
  assign cur_bit   = LSB_FIRST ? txbyte_q[bitcnt_q[2:0]] : txbyte_q[3'd7 - bitcnt_q[2:0]];

  // Protocol FSM with registered bus and register-file outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      txbyte_q    <= '0;
      bitcnt_q    <= '0;
      ack_ph_q    <= 1'b0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sda_oe_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      start_det_q <= 1'b0;
      if (start_cond) begin
        state_q     <= S_ADDR;
        bitcnt_q    <= '0;
        ack_ph_q    <= 1'b0;
        sda_oe_q    <= 1'b0;
        busy_q      <= 1'b0;
        start_det_q <= 1'b1;
      end else if (stop_cond) begin
        state_q  <= S_IDLE;
        ack_ph_q <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              shift_q  <= rx_byte[6:0];
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7) begin
                bitcnt_q <= '0;
                if (state_q == S_ADDR) begin
                  if (addr_rx == DEV_ADDR) begin
                    state_q <= S_ADDR_ACK;
                    busy_q  <= 1'b1;
                    rw_q    <= rx_byte[0];
                  end else begin
                    state_q <= S_IGNORE;
                  end
                end else if (state_q == S_PTR) begin
                  if (ptr_ok) begin
                    ptr_q   <= data_byte[REG_AW-1:0];
                    state_q <= S_PTR_ACK;
                  end else begin
                    state_q <= S_NACK;
                  end
                end else begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= ptr_q;
                  wr_data_q <= data_byte;
                  ptr_q     <= ptr_d;
                  state_q   <= S_WDATA_ACK;
                end
              end
            end
          end
          // First SCL fall drives the ACK, second fall ends the ACK slot
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_ph_q) begin
                ack_ph_q <= 1'b1;
                sda_oe_q <= 1'b1;
              end else begin
                ack_ph_q <= 1'b0;
                if (state_q == S_ADDR_ACK && rw_q) begin
                  txbyte_q <= rd_data;
                  sda_oe_q <= ~first_bit;
                  bitcnt_q <= '0;
                  state_q  <= S_RDATA;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                bitcnt_q <= '0;
                sda_oe_q <= 1'b0;
                state_q  <= S_RACK;
              end else begin
                sda_oe_q <= ~cur_bit;
              end
            end
          end
          // Pointer advances at the ACK sample; rd_data reflects it by the following fall
          S_RACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ptr_q    <= ptr_d;
                ack_ph_q <= 1'b1;
              end else begin
                state_q <= S_IGNORE;
              end
            end else if (scl_fall && ack_ph_q) begin
              ack_ph_q <= 1'b0;
              txbyte_q <= rd_data;
              sda_oe_q <= ~first_bit;
              bitcnt_q <= '0;
              state_q  <= S_RDATA;
            end
          end
          S_NACK: begin
            if (scl_fall) begin
              if (!ack_ph_q) begin
                ack_ph_q <= 1'b1;
              end else begin
                ack_ph_q <= 1'b0;
                state_q  <= S_IGNORE;
              end
            end
          end
          S_IGNORE: sda_oe_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = ptr_q;
  assign busy      = busy_q;
  assign start_det = start_det_q;

endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
Second-generation I2C target (peripheral). Oversamples SCL/SDA on the system clock and decodes START, repeated START and STOP. Supports write and read transfers to an external byte register file through a register-pointer protocol with auto-increment. It replaces the SCL-clocked single-transfer peripheral and adds read mode, multi-byte bursts, address filtering, NACK on bad pointers and bit-order selection.

Parameters:
DEV_ADDR, 7'h42, 7-bit target address matched after START
NUM_REGS, 16, register-file depth, 2..256
REG_AW, $clog2(NUM_REGS), register address width, derived
SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in, >=2
LSB_FIRST, 0, 1 = address/data bytes shifted LSB-first (legacy bench compatibility); 0 = standard MSB-first

Ports:
clk  in  1  system clock; must be >=16x SCL frequency
reset_n  in  1  asynchronous, active-low reset
scl_in  in  1  bus SCL level (asynchronous)
sda_in  in  1  bus SDA level (asynchronous)
sda_oe  out  1  1 = pull SDA low (open drain); 0 = release
wr_en  out  1  one-cycle register write strobe
wr_addr  out  REG_AW  write register index
wr_data  out  8  write data
rd_addr  out  REG_AW  read register index, held stable
rd_data  in  8  register contents at rd_addr, combinational, valid same cycle
busy  out  1  1 from matched address until STOP/START
start_det  out  1  one-cycle pulse per START or repeated START

Behaviour:
- Reset (async assert, sync release): state IDLE; sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, start_det=0; pointer=0; bit counter=0; synchronisers = 1.
- Edge detect on synchronised signals. SCL rise/fall = change of synced SCL. START = synced SDA 1->0 while SCL high. STOP = synced SDA 0->1 while SCL high.
- START/STOP take priority over any state. START -> ADDR, bit count 0, start_det pulse, pointer retained. STOP -> IDLE, busy=0, sda_oe=0.
- Data bits sample on SCL rise. sda_oe updates on SCL fall, within SYNC_STAGES+2 clk.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W, R/W last). On match -> ADDR_ACK, busy=1. On mismatch -> IGNORE.
  - ADDR_ACK: sda_oe=1 for one SCL low period. Then R/W=0 -> PTR; R/W=1 -> load rd_data into the shift register at SCL fall -> RDATA.
  - PTR: shift 8 bits. Value < NUM_REGS -> load pointer -> PTR_ACK. Otherwise -> NACK state (sda_oe stays 0), then IGNORE.
  - PTR_ACK / WDATA_ACK: ACK, then -> WDATA.
  - WDATA: on the 8th rising sample, wr_en=1 for 1 clk with wr_addr=pointer and wr_data=byte. Pointer then increments mod NUM_REGS (NUM_REGS-1 -> 0). -> WDATA_ACK.
  - RDATA: sda_oe = ~current bit, driven on SCL fall. After the 8th bit, release SDA -> RACK.
  - RACK: sample the controller's bit on SCL rise. 0 (ACK) -> pointer++ mod NUM_REGS, reload rd_data, -> RDATA. 1 (NACK) -> IGNORE.
  - IGNORE: sda_oe=0 until START/STOP.
- rd_addr = pointer at all times. rd_data is sampled only at load instants.
- LSB_FIRST selects shift direction for the address byte and data bytes alike. R/W is always the 8th bit.
- Repeated START mid-byte: discard partial byte; no wr_en.
- reset_n low mid-transfer: immediate return to reset values; bus released.

Test Plan:
- Write burst: START, 0x84 (0x42,W), ptr 0x03, data 0x66, 0x67, STOP -> ACK on all 4 bytes; wr_en at (3,0x66) then (4,0x67); busy falls at STOP.
- Address mismatch: START, 0x86 (0x43,W), 0x03 -> sda_oe=0 throughout; no wr_en; busy=0.
- Read with repeated START: write ptr 0x05; Sr; 0x85; controller ACK, ACK, NACK with regs[5..7]=0xA1,0xB2,0xC3 -> SDA shows A1, B2, C3 MSB-first; then released.
- Wrap: ptr 0x0F, write 0x11, 0x22 -> wr_en at (15,0x11) then (0,0x22).
- Bad pointer: ptr 0x20 with NUM_REGS=16 -> NACK; following data byte ignored; no wr_en.
- reset_n pulsed low after 4 data bits; LSB_FIRST=1 rerun of the write-burst scenario -> sda_oe=0 immediately after reset, pointer=0; legacy LSB-first stream decodes identically.
